// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: definitions shared by the program loader, its opcode
// checker and the core's decode blocks (imm_gen, control unit).
//   - RV32 base opcode constants for the instruction classes the core runs
//   - loader FSM state encoding
//   - err_code values reported by the loader
package prog_loader_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_LEN    = 2'b01,
        ERR_OPCODE = 2'b10
    } err_code_t;

endpackage

// File: rtl/opcode_check.sv
// opcode_check: combinational legality test for an assembled instruction.
// Ports:
//   instr  in  32  instruction word
//   legal  out  1  high when instr[6:0] is one of the opcodes the core executes
module opcode_check
    import prog_loader_pkg::*;
(
    input  logic [31:0] instr,
    output logic        legal
);

    logic [6:0] opcode;
    logic       unused_bits;

    assign opcode = instr[6:0];

    // Only the opcode field decides legality; the rest of the word is
    // deliberately ignored.
    assign unused_bits = ^instr[31:7];

    assign legal = opcode inside {OP_LOAD, OP_STORE, OP_IMM, OP_BRANCH, OP_RTYPE};

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a program as a byte stream, assembles 32-bit words,
// checks each opcode and writes the words into instruction memory while
// holding the multicycle core in reset.
// Stream: 16-bit little-endian word count N, then N little-endian words.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a load (sampled in IDLE, DONE, ERR)
//   rx_data/rx_valid      incoming byte and its valid
//   rx_ready              loader accepts a byte this cycle
//   mem_we/addr/wdata     one-cycle instruction-memory write port
//   cpu_hold              core held in reset until the program is complete
//   done/err/err_code     completion / abort status levels
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    // Wide enough to hold DEPTH_WORDS itself so the index never wraps.
    localparam int IDX_W = $clog2(DEPTH_WORDS + 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] index_q;
    logic [1:0]       byte_cnt_q;
    logic [15:0]      count_q;
    logic [31:0]      word_q;
    err_code_t        err_code_q;

    logic             opcode_legal;
    logic [15:0]      len_full;
    logic             last_word;

    // Control strobes from the FSM to the datapath registers.
    logic             begin_load;
    logic             cap_len_lo;
    logic             cap_len_hi;
    logic             cap_byte;
    logic             advance;
    logic             set_len_err;
    logic             set_op_err;

    opcode_check u_opcode_check (
        .instr (word_q),
        .legal (opcode_legal)
    );

    // Full count as it will be once the high byte currently on rx_data lands.
    assign len_full  = {rx_data, count_q[7:0]};
    assign last_word = (16'(index_q) + 16'd1) == count_q;

    // State register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        rx_ready    = 1'b0;
        mem_we      = 1'b0;
        begin_load  = 1'b0;
        cap_len_lo  = 1'b0;
        cap_len_hi  = 1'b0;
        cap_byte    = 1'b0;
        advance     = 1'b0;
        set_len_err = 1'b0;
        set_op_err  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    begin_load = 1'b1;
                    state_d    = ST_LEN0;
                end
            end
            ST_LEN0: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    cap_len_lo = 1'b1;
                    state_d    = ST_LEN1;
                end
            end
            ST_LEN1: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    cap_len_hi = 1'b1;
                    if (len_full == 16'd0) begin
                        state_d = ST_DONE;
                    end else if (int'(len_full) > DEPTH_WORDS) begin
                        set_len_err = 1'b1;
                        state_d     = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    cap_byte = 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (opcode_legal) begin
                    mem_we  = 1'b1;
                    advance = 1'b1;
                    state_d = last_word ? ST_DONE : ST_DATA;
                end else begin
                    set_op_err = 1'b1;
                    state_d    = ST_ERR;
                end
            end
            ST_DONE, ST_ERR: begin
                if (start) begin
                    begin_load = 1'b1;
                    state_d    = ST_LEN0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q    <= '0;
            byte_cnt_q <= 2'd0;
            count_q    <= 16'd0;
            word_q     <= 32'd0;
            err_code_q <= ERR_NONE;
        end else begin
            if (begin_load) begin
                index_q    <= '0;
                byte_cnt_q <= 2'd0;
                count_q    <= 16'd0;
                err_code_q <= ERR_NONE;
            end
            if (cap_len_lo) begin
                count_q[7:0] <= rx_data;
            end
            if (cap_len_hi) begin
                count_q[15:8] <= rx_data;
            end
            if (cap_byte) begin
                // Shift right so the first byte of a word ends up in [7:0].
                word_q     <= {rx_data, word_q[31:8]};
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end
            if (advance) begin
                index_q <= index_q + IDX_W'(1);
            end
            if (set_len_err) begin
                err_code_q <= ERR_LEN;
            end
            if (set_op_err) begin
                err_code_q <= ERR_OPCODE;
            end
        end
    end

    assign mem_addr  = ADDR_W'({index_q, 2'b00});
    assign mem_wdata = word_q;
    assign cpu_hold  = (state_q != ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign err       = (state_q == ST_ERR);
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader.
// Table-driven load vectors plus hand-written sequences for the full-depth
// load and a reset in the middle of a load. Expected memory writes go into a
// scoreboard queue as stimulus is driven and are popped by a write monitor.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [1:0]        err_code;

    prog_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected memory writes
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t               exp_q[$];
    logic [ADDR_W-1:0] last_addr = '0;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", mem_we, 1'b0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", mem_addr, e.addr);
                check("write_data", mem_wdata, e.data);
            end
            last_addr = mem_addr;
        end
    end

    task automatic push_write(input int idx, input logic [31:0] w);
        wr_t e;
        e.addr = ADDR_W'(idx * 4);
        e.data = w;
        exp_q.push_back(e);
    endtask

    // All stimulus tasks start and end at posedge+1.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int budget;
        bit sent;
        budget = 200;
        sent   = 1'b0;
        while (!sent && budget > 0) begin
            rx_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            rx_data  = rx_valid ? b : 8'($urandom);
            @(negedge clk);
            if (rx_valid && rx_ready) sent = 1'b1;
            @(posedge clk); #1;
            budget--;
        end
        rx_valid = 1'b0;
        if (!sent) check("byte_accept", sent, 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        send_byte(w[7:0], gaps);
        send_byte(w[15:8], gaps);
        send_byte(w[23:16], gaps);
        send_byte(w[31:24], gaps);
    endtask

    // Returns at a negedge with done or err high (or budget expired);
    // lat counts whole cycles waited beyond the first negedge.
    task automatic wait_end(output int lat);
        lat = 0;
        @(negedge clk);
        while (!(done || err) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [15:0] len;
        logic [31:0] w0;
        logic [31:0] w1;
        int          nsend;
        int          nwrites;
        logic        exp_done;
        logic        exp_err;
        logic [1:0]  exp_code;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          c0;
        vec_t        v;
        logic [15:0] lenv;
        logic [31:0] w;

        //            len       w0            w1            send wr done err code
        vecs[0] = '{16'd2,      32'h00A00093, 32'h00002183, 2, 2, 1'b1, 1'b0, 2'b00};
        vecs[1] = '{16'd0,      32'h0,        32'h0,        0, 0, 1'b1, 1'b0, 2'b00};
        vecs[2] = '{16'h0101,   32'h0,        32'h0,        0, 0, 1'b0, 1'b1, 2'b01};
        vecs[3] = '{16'd1,      32'hFFFFFFFF, 32'h0,        1, 0, 1'b0, 1'b1, 2'b10};
        vecs[4] = '{16'd1,      32'h00000013, 32'h0,        1, 1, 1'b1, 1'b0, 2'b00};
        vecs[5] = '{16'd2,      32'h00000033, 32'h00000063, 2, 2, 1'b1, 1'b0, 2'b00};
        vecs[6] = '{16'd2,      32'h00002023, 32'h0000007F, 2, 1, 1'b0, 1'b1, 2'b10};
        vecs[7] = '{16'd2,      32'h00000037, 32'h00000013, 1, 0, 1'b0, 1'b1, 2'b10};
        vecs[8] = '{16'h8000,   32'h0,        32'h0,        0, 0, 1'b0, 1'b1, 2'b01};

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err, err_code},
              {1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 2'b00});
        @(posedge clk); #1;
        rst_n = 1'b1;

        // IDLE ignores bytes without start
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        @(negedge clk);
        check("idle_not_ready", {rx_ready, cpu_hold}, 2'b01);
        @(posedge clk); #1;
        rx_valid = 1'b0;

        // Table-driven loads, chained through DONE/ERR restarts
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            pulse_start();
            @(negedge clk);
            check("after_start", {done, err, err_code, cpu_hold, rx_ready}, 6'b000011);
            @(posedge clk); #1;
            lenv = v.len;
            send_byte(lenv[7:0], 1'b0);
            send_byte(lenv[15:8], 1'b0);
            for (int k = 0; k < v.nsend; k++) begin
                w = (k == 0) ? v.w0 : v.w1;
                if (k < v.nwrites) push_write(k, w);
                send_word(w, 1'b0);
            end
            wait_end(lat);
            check("end_latency", lat, (v.nsend == 0) ? 0 : 1);
            check("end_status", {done, err, err_code, cpu_hold, rx_ready},
                  {v.exp_done, v.exp_err, v.exp_code, ~v.exp_done, 1'b0});
            check("pending_writes", exp_q.size(), 0);
            @(posedge clk); #1;
        end

        // Full-depth load, back-to-back bytes: 5 cycles per word
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        c0 = cyc;
        for (int i = 0; i < DEPTH; i++) begin
            w = {16'(i), 16'h0013};
            push_write(i, w);
            send_word(w, 1'b0);
        end
        wait_end(lat);
        check("n256_cycles", cyc - c0, DEPTH * 5);
        check("n256_status", {done, err, err_code, cpu_hold}, 5'b10000);
        check("n256_last_addr", last_addr, 10'h3FC);
        check("n256_pending", exp_q.size(), 0);
        @(posedge clk); #1;

        // N=3 with random gaps, start held (ignored), reset after word 1
        pulse_start();
        start = 1'b1;
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        push_write(0, 32'h00500113);
        send_word(32'h00500113, 1'b1);
        @(posedge clk); #1;
        check("mid_word1_written", exp_q.size(), 0);
        send_byte(8'h83, 1'b1);
        send_byte(8'h21, 1'b1);
        start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs",
              {rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err, err_code},
              {1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 2'b00});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 8'($urandom);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            @(negedge clk);
            check("post_reset_idle", {rx_ready, cpu_hold, done, err}, 4'b0100);
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        check("post_reset_no_writes", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: instruction memory capacity in 32-bit words.
REQ-002 Parameter ADDR_W, default 10: byte-address width of mem_addr.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin a load; sampled only in IDLE, DONE or ERR.
REQ-006 rx_data  input  8  incoming program byte.
REQ-007 rx_valid  input  1  rx_data valid.
REQ-008 rx_ready  output  1  loader accepts a byte this cycle; a transfer occurs when rx_valid and rx_ready are both high.
REQ-009 mem_we  output  1  one-cycle instruction-memory write strobe.
REQ-010 mem_addr  output  ADDR_W  word-aligned byte address; bits [1:0] always 0.
REQ-011 mem_wdata  output  32  assembled instruction word.
REQ-012 cpu_hold  output  1  holds the multicycle core in reset while the program is incomplete.
REQ-013 done  output  1  level: program loaded successfully.
REQ-014 err  output  1  level: load aborted.
REQ-015 err_code  output  2  01 = length too large, 10 = illegal opcode, 00 otherwise.

Function
REQ-016 Stream format: 2-byte little-endian word count N, then 4N bytes, each word little-endian (first byte -> bits [7:0]).
REQ-017 FSM states: IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR.
REQ-018 IDLE: start=1 -> LEN0; otherwise stay.
REQ-019 LEN0/LEN1: rx_ready=1; each accepted byte captures count low/high byte; LEN1 transfer moves to DATA, DONE (N=0) or ERR (N>DEPTH_WORDS, err_code=01).
REQ-020 DATA: rx_ready=1; a 2-bit byte counter increments per transfer; the 4th transfer moves to WRITE the next cycle.
REQ-021 WRITE: rx_ready=0; if opcode bits [6:0] are one of 0000011, 0100011, 0010011, 1100011, 0110011, mem_we=1 for exactly this cycle with mem_addr=index*4 and mem_wdata=assembled word; otherwise there is no write and the FSM moves to ERR with err_code=10.
REQ-022 After a legal write, index increments; if index+1 equals N -> DONE, else -> DATA.
REQ-023 Cycles with rx_valid=0 stall the FSM with no state change; rx_data is ignored when rx_valid=0.
REQ-024 start is ignored in LEN0, LEN1, DATA and WRITE.
REQ-025 DONE: done=1, cpu_hold=0, rx_ready=0; start=1 -> LEN0, cpu_hold re-asserted the next cycle.
REQ-026 ERR: err=1, cpu_hold=1, rx_ready=0; start=1 -> LEN0, clearing err and err_code.
REQ-027 cpu_hold=1 in every state except DONE.
REQ-028 Minimum throughput is 1 byte/cycle in DATA, plus 1 WRITE cycle per word.
REQ-029 N=DEPTH_WORDS is legal; the last write goes to address (DEPTH_WORDS-1)*4, and index never wraps.

Reset
REQ-030 rst_n low asynchronously forces IDLE and sets: index=0, byte counter=0, count=0, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, err=0, err_code=00.
REQ-031 Reset asserted mid-load abandons the load, with no further mem_we; memory contents already written are left untouched.

Structure
REQ-032 A shared package prog_loader_pkg holds: the opcode constants (OP_LOAD, OP_STORE, OP_IMM, OP_BRANCH, OP_RTYPE), also used by imm_gen and the control unit; the FSM state encoding; and err_code values.
REQ-033 Opcode legality is implemented as one combinational sub-module, opcode_check (32-bit in, legal out).

Verification
REQ-034 Load N=2 with words 0x00A00093 and 0x00002183, back-to-back bytes -> two mem_we pulses at addresses 0x000 and 0x004 with those data, then done=1 and cpu_hold=0.
REQ-035 Send count bytes 0x00, 0x00 (N=0) -> DONE immediately after the 2nd byte, with no mem_we.
REQ-036 Send count 0x0101 (257) -> err=1, err_code=01, no mem_we, rx_ready=0.
REQ-037 Send N=1 with word 0xFFFFFFFF -> no mem_we, err=1, err_code=10; then assert start and load a valid N=1 word -> done=1.
REQ-038 Send N=3 with rx_valid toggling randomly and rst_n pulsed low after word 1 -> word 1 is written only, then IDLE with all reset values.
REQ-039 Send N=256 -> 256 writes, the last at address 0x3FC, followed by done=1.
